mac_seq_ctrl: RTL

//  Sequencer that drives one external sign-magnitude MAC unit (clk/en/done handshake) to

---
 rtl/mac_seq_ctrl_pkg.sv | 36 +++
 rtl/mac_seq_ctrl_if.sv | 41 ++++
 rtl/mac_seq_ctrl_fb_sat.sv | 23 ++
 rtl/mac_seq_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared widths, FSM state encoding and sign-magnitude helpers for the MAC sequencer.
// No logic of its own.
// Imported by the interface, the saturation block and the controller.
package mac_seq_ctrl_pkg;

  localparam int A_BITWIDTH    = 8;
  localparam int OUT_BITWIDTH  = 19;
  localparam int C_BITWIDTH    = OUT_BITWIDTH - 1;
  localparam int CNT_BITWIDTH  = 8;
  localparam int TIMEOUT       = 15;
  localparam int WAIT_BITWIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [CNT_BITWIDTH-1:0]  cnt_t;
  typedef logic [WAIT_BITWIDTH-1:0] wait_t;

  // Longest vector: the counter must never wrap back to zero.
  localparam cnt_t CNT_MAX = '1;

  // Largest representable addend with the given sign.
  function automatic logic [C_BITWIDTH-1:0] sm_c_sat(input logic sign);
    return {sign, {(C_BITWIDTH-1){1'b1}}};
  endfunction

  // Sign bit of a sign-magnitude result word.
  function automatic logic sm_out_sign(input logic [OUT_BITWIDTH-1:0] v);
    return v[OUT_BITWIDTH-1];
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of operand stream, MAC handshake and result signals around the sequencer.
// No latency; wires only.
// Operand stream uses valid/ready; result is a one-cycle strobe with no backpressure.
interface mac_seq_ctrl_if;
  import mac_seq_ctrl_pkg::*;

  logic                    start;
  logic [C_BITWIDTH-1:0]   bias;
  logic                    in_valid;
  logic                    in_ready;
  logic [A_BITWIDTH-1:0]   in_a;
  logic [A_BITWIDTH-1:0]   in_b;
  logic                    in_last;
  logic                    mac_en;
  logic [A_BITWIDTH-1:0]   mac_a;
  logic [A_BITWIDTH-1:0]   mac_b;
  logic [C_BITWIDTH-1:0]   mac_c;
  logic [OUT_BITWIDTH-1:0] mac_mout;
  logic                    mac_done;
  logic                    busy;
  logic                    out_valid;
  logic [OUT_BITWIDTH-1:0] out_data;
  logic [CNT_BITWIDTH-1:0] out_cnt;
  logic                    out_ovf;
  logic                    out_err;

  // Controller side.
  modport master (
    input  start, bias, in_valid, in_a, in_b, in_last, mac_mout, mac_done,
    output in_ready, mac_en, mac_a, mac_b, mac_c, busy,
           out_valid, out_data, out_cnt, out_ovf, out_err
  );

  // Environment side: operand source, MAC unit and result sink.
  modport slave (
    output start, bias, in_valid, in_a, in_b, in_last, mac_mout, mac_done,
    input  in_ready, mac_en, mac_a, mac_b, mac_c, busy,
           out_valid, out_data, out_cnt, out_ovf, out_err
  );

endinterface

// File: rtl/mac_seq_ctrl_fb_sat.sv
// Narrows a MAC result to the addend width, clamping the magnitude when it overflows.
// Purely combinational.
// No handshake.
module mac_fb_sat
  import mac_seq_ctrl_pkg::*;
(
  input  logic [OUT_BITWIDTH-1:0] mout,
  output logic [C_BITWIDTH-1:0]   c,
  output logic                    ovf
);

  // Drop the top magnitude bit when it is clear; otherwise clamp and flag.
  // The sign is carried through untouched, so -0 stays -0.
  always_comb begin
    c   = {sm_out_sign(mout), mout[OUT_BITWIDTH-3:0]};
    ovf = 1'b0;
    if (mout[OUT_BITWIDTH-2]) begin
      c   = sm_c_sat(sm_out_sign(mout));
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one external sign-magnitude MAC over a streamed vector to give sum(a*b)+bias.
// One MAC pass per pair; the result strobes 2 cycles after the final mac_done.
// Operands are taken only in FETCH (in_ready); the result strobe cannot be stalled.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.master bus
);

  state_t                  state_q, state_d;
  logic [A_BITWIDTH-1:0]   a_q, b_q;
  logic                    last_q;
  logic [C_BITWIDTH-1:0]   c_q;
  cnt_t                    cnt_q;
  logic                    ovf_q, err_q;
  wait_t                   wait_q;
  logic [OUT_BITWIDTH-1:0] res_q;
  logic                    out_valid_q;
  logic [OUT_BITWIDTH-1:0] out_data_q;
  cnt_t                    out_cnt_q;
  logic                    out_ovf_q, out_err_q;

  logic [C_BITWIDTH-1:0]   sat_c;
  logic                    sat_ovf;
  cnt_t                    cnt_inc;
  logic                    cnt_at_max;
  logic                    timeout_hit;

  mac_fb_sat u_fb_sat (
    .mout (bus.mac_mout),
    .c    (sat_c),
    .ovf  (sat_ovf)
  );

  assign cnt_inc     = cnt_q + cnt_t'(1);
  assign cnt_at_max  = (cnt_inc == CNT_MAX);
  assign timeout_hit = (wait_q == wait_t'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: one MAC pass per accepted pair, abort on length or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: if (bus.in_valid) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.mac_done)  state_d = (last_q || cnt_at_max) ? ST_DONE : ST_FETCH;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand, accumulator, count and flag registers for the vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      c_q    <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      wait_q <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          c_q   <= bus.bias;
          cnt_q <= '0;
          ovf_q <= 1'b0;
          err_q <= 1'b0;
        end
        ST_FETCH: if (bus.in_valid) begin
          a_q    <= bus.in_a;
          b_q    <= bus.in_b;
          last_q <= bus.in_last;
          wait_q <= '0;
        end
        ST_RUN: begin
          if (bus.mac_done) begin
            cnt_q <= cnt_inc;
            c_q   <= sat_c;
            res_q <= bus.mac_mout;
            if (sat_ovf)    ovf_q <= 1'b1;
            if (cnt_at_max) err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + wait_t'(1);
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded from DONE so out_data stays put between strobes,
  // and a timeout delivers the last MAC result that did arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        out_data_q <= res_q;
        out_cnt_q  <= cnt_q;
        out_ovf_q  <= ovf_q;
        out_err_q  <= err_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_FETCH);
  assign bus.mac_en    = (state_q == ST_RUN);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mac_a     = a_q;
  assign bus.mac_b     = b_q;
  assign bus.mac_c     = c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_err   = out_err_q;

endmodule
